// File: rtl/hilo_unit_pkg.sv
// hilo_unit_pkg: shared types for the HI/LO writeback path.
//   word_t       - datapath word
//   funct_t      - R-type funct codes touching HI/LO
//   hilo_entry_t - one pending HI/LO write carried through a pipeline slot
//   fn_hi_we / fn_lo_we - write-enable decode from a funct code
package hilo_unit_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [5:0] {
    FN_MFHI  = 6'h10,
    FN_MTHI  = 6'h11,
    FN_MFLO  = 6'h12,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1a,
    FN_DIVU  = 6'h1b
  } funct_t;

  typedef struct packed {
    logic  valid;
    logic  hi_we;
    logic  lo_we;
    word_t hi;
    word_t lo;
  } hilo_entry_t;

  function automatic logic fn_is_muldiv(logic [5:0] op);
    return (op == FN_MULT) || (op == FN_MULTU) || (op == FN_DIV) || (op == FN_DIVU);
  endfunction

  function automatic logic fn_hi_we(logic [5:0] op);
    return fn_is_muldiv(op) || (op == FN_MTHI);
  endfunction

  function automatic logic fn_lo_we(logic [5:0] op);
    return fn_is_muldiv(op) || (op == FN_MTLO);
  endfunction

endpackage

// File: rtl/hilo_slot.sv
// hilo_slot: one pipeline slot holding a pending HI/LO write.
//   clk, reset - clock, asynchronous active-high reset (slot becomes empty)
//   load       - capture d at the edge
//   clear      - empty the slot at the edge (wins over load)
//   d          - incoming entry
//   q          - current entry
module hilo_slot
  import hilo_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  hilo_entry_t d,
  output hilo_entry_t q
);

  hilo_entry_t entry_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
    end else if (clear) begin
      entry_q <= '0;
    end else if (load) begin
      entry_q <= d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: carries HI/LO writes from EX through M and W slots into the
// architectural HI/LO registers, and forwards pending values to EX readers.
//   clk, reset       - clock, asynchronous active-high reset
//   stall            - hold M, W and arch this edge
//   flush            - kill EX capture and M slot; W still commits
//   ex_valid, ex_op  - EX instruction valid and funct code
//   ex_hi, ex_lo     - multiply/divide (or MTHI/MTLO) results in EX
//   hi_rd, lo_rd     - HI/LO as seen by the EX instruction
//   hi_arch, lo_arch - committed HI/LO
//   pend             - a valid write is in M or W
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int unsigned W      = WORD_W,  // must equal WORD_W (entry fields are word_t)
  parameter bit          FWD_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic         ex_valid,
  input  logic [5:0]   ex_op,
  input  logic [W-1:0] ex_hi,
  input  logic [W-1:0] ex_lo,
  output logic [W-1:0] hi_rd,
  output logic [W-1:0] lo_rd,
  output logic [W-1:0] hi_arch,
  output logic [W-1:0] lo_arch,
  output logic         pend
);

  hilo_entry_t ex_entry, m_entry, w_entry;
  logic        slot_load, slot_clear, commit;
  logic [W-1:0] hi_arch_q, lo_arch_q;

  always_comb begin
    ex_entry       = '0;
    ex_entry.hi_we = fn_hi_we(ex_op);
    ex_entry.lo_we = fn_lo_we(ex_op);
    ex_entry.valid = ex_valid & (ex_entry.hi_we | ex_entry.lo_we);
    ex_entry.hi    = ex_hi;
    ex_entry.lo    = ex_lo;
  end

  // Flush empties both slots; the W entry is older than the faulting
  // instruction, so it still commits on the same edge.
  assign slot_clear = flush;
  assign slot_load  = ~stall;
  assign commit     = w_entry.valid & (flush | ~stall);

  hilo_slot u_m_slot (
    .clk   (clk),
    .reset (reset),
    .load  (slot_load),
    .clear (slot_clear),
    .d     (ex_entry),
    .q     (m_entry)
  );

  hilo_slot u_w_slot (
    .clk   (clk),
    .reset (reset),
    .load  (slot_load),
    .clear (slot_clear),
    .d     (m_entry),
    .q     (w_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_arch_q <= '0;
      lo_arch_q <= '0;
    end else if (commit) begin
      if (w_entry.hi_we) hi_arch_q <= w_entry.hi;
      if (w_entry.lo_we) lo_arch_q <= w_entry.lo;
    end
  end

  assign hi_arch = hi_arch_q;
  assign lo_arch = lo_arch_q;
  assign pend    = m_entry.valid | w_entry.valid;

  // HI and LO resolve independently: an MTHI in M must not hide a LO write in W.
  generate
    if (FWD_EN) begin : g_fwd
      always_comb begin
        hi_rd = hi_arch_q;
        if (m_entry.valid && m_entry.hi_we)      hi_rd = m_entry.hi;
        else if (w_entry.valid && w_entry.hi_we) hi_rd = w_entry.hi;
        lo_rd = lo_arch_q;
        if (m_entry.valid && m_entry.lo_we)      lo_rd = m_entry.lo;
        else if (w_entry.valid && w_entry.lo_we) lo_rd = w_entry.lo;
      end
    end else begin : g_nofwd
      assign hi_rd = hi_arch_q;
      assign lo_rd = lo_arch_q;
    end
  endgenerate

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, ex_valid;
  logic [5:0]  ex_op;
  logic [31:0] ex_hi, ex_lo, hi_rd, lo_rd, hi_arch, lo_arch;
  logic        pend;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hilo_unit #(.W(32), .FWD_EN(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .ex_valid (ex_valid),
    .ex_op    (ex_op),
    .ex_hi    (ex_hi),
    .ex_lo    (ex_lo),
    .hi_rd    (hi_rd),
    .lo_rd    (lo_rd),
    .hi_arch  (hi_arch),
    .lo_arch  (lo_arch),
    .pend     (pend)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns after that.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [5:0] op, input logic [31:0] hi,
                        input logic [31:0] lo);
    ex_valid = v;
    ex_op    = op;
    ex_hi    = hi;
    ex_lo    = lo;
    #1;
  endtask

  task automatic idle();
    set_ex(1'b0, 6'h00, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; ex_op = '0; ex_hi = '0; ex_lo = '0;
    #12;
    reset = 1'b0;
    step();
    idle();

    // Reset then idle
    check_eq("rst_hi_rd", hi_rd, 32'h0);
    check_eq("rst_lo_rd", lo_rd, 32'h0);
    check_eq("rst_hi_arch", hi_arch, 32'h0);
    check_eq("rst_lo_arch", lo_arch, 32'h0);
    check_eq("rst_pend", {31'b0, pend}, 32'h0);

    // Non-writing op and invalid MULT do not create pending writes
    set_ex(1'b1, FN_MFLO, 32'hdead, 32'hbeef);
    step();
    check_eq("mflo_no_pend", {31'b0, pend}, 32'h0);
    set_ex(1'b0, FN_MULT, 32'hdead, 32'hbeef);
    step();
    check_eq("inv_mult_no_pend", {31'b0, pend}, 32'h0);
    check_eq("inv_mult_hi_rd", hi_rd, 32'h0);

    // MULT forwarding from M, then commit
    set_ex(1'b1, FN_MULT, 32'h1, 32'h2);
    step();
    set_ex(1'b1, FN_MFHI, 32'h0, 32'h0);
    check_eq("mult_m_fwd_hi", hi_rd, 32'h1);
    check_eq("mult_m_fwd_lo", lo_rd, 32'h2);
    check_eq("mult_pend", {31'b0, pend}, 32'h1);
    check_eq("mult_arch_early", hi_arch, 32'h0);
    step();
    idle();
    check_eq("mult_w_fwd_hi", hi_rd, 32'h1);
    step();
    check_eq("mult_hi_arch", hi_arch, 32'h1);
    check_eq("mult_lo_arch", lo_arch, 32'h2);
    check_eq("mult_pend_done", {31'b0, pend}, 32'h0);

    // MTHI then MTLO back-to-back; per-half forwarding
    set_ex(1'b1, FN_MTHI, 32'haaaa, 32'h1234);
    step();
    set_ex(1'b1, FN_MTLO, 32'h4321, 32'h5555);
    step();
    idle();
    check_eq("mt_hi_rd_w", hi_rd, 32'haaaa);
    check_eq("mt_lo_rd_m", lo_rd, 32'h5555);
    step();
    step();
    check_eq("mt_hi_arch", hi_arch, 32'haaaa);
    check_eq("mt_lo_arch", lo_arch, 32'h5555);

    // DIVU then MTLO; MFLO sees MTLO, HI comes from DIVU in W
    set_ex(1'b1, FN_DIVU, 32'h3, 32'h7);
    step();
    set_ex(1'b1, FN_MTLO, 32'h77, 32'h9);
    step();
    set_ex(1'b1, FN_MFLO, 32'h0, 32'h0);
    check_eq("divu_lo_rd", lo_rd, 32'h9);
    check_eq("divu_hi_rd", hi_rd, 32'h3);
    step();
    idle();
    check_eq("divu_lo_arch_mid", lo_arch, 32'h7);
    check_eq("divu_lo_rd_mid", lo_rd, 32'h9);
    step();
    check_eq("divu_lo_arch", lo_arch, 32'h9);
    check_eq("divu_hi_arch", hi_arch, 32'h3);

    // Flush with MULT in M, MTHI in W; EX capture also killed
    set_ex(1'b1, FN_MTHI, 32'h11, 32'h0);
    step();
    set_ex(1'b1, FN_MULT, 32'h22, 32'h33);
    step();
    set_ex(1'b1, FN_MULTU, 32'h88, 32'h99);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check_eq("flush_pend", {31'b0, pend}, 32'h0);
    check_eq("flush_hi_arch", hi_arch, 32'h11);
    check_eq("flush_lo_arch", lo_arch, 32'h9);
    check_eq("flush_lo_rd", lo_rd, 32'h9);
    step();
    check_eq("flush_hi_arch_after", hi_arch, 32'h11);

    // Stall with MULT in M
    set_ex(1'b1, FN_MULT, 32'h44, 32'h55);
    step();
    stall = 1'b1;
    set_ex(1'b1, FN_MTHI, 32'h99, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_hi_arch", hi_arch, 32'h11);
      check_eq("stall_hi_rd", hi_rd, 32'h44);
      check_eq("stall_pend", {31'b0, pend}, 32'h1);
    end
    stall = 1'b0;
    idle();
    step();
    check_eq("unstall_hi_arch_mid", hi_arch, 32'h11);
    step();
    check_eq("unstall_hi_arch", hi_arch, 32'h44);
    check_eq("unstall_lo_arch", lo_arch, 32'h55);
    check_eq("unstall_no_mthi", {31'b0, pend}, 32'h0);

    // Reset mid-flight discards pending write
    set_ex(1'b1, FN_MTHI, 32'h66, 32'h0);
    step();
    idle();
    check_eq("pre_rst_hi_rd", hi_rd, 32'h66);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_pend", {31'b0, pend}, 32'h0);
    check_eq("mid_rst_hi_arch", hi_arch, 32'h0);
    check_eq("mid_rst_lo_arch", lo_arch, 32'h0);
    check_eq("mid_rst_hi_rd", hi_rd, 32'h0);
    step();
    reset = 1'b0;
    step();
    step();
    check_eq("post_rst_hi_arch", hi_arch, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
